cache_fill_fsm: RTL and testbench

- Reads one full cache block from the team's multi-cycle main memory after a cache miss.
- Sits between the I-/D-cache miss logic and the memory model.
- Issues one word-read request per cycle, then counts the returning words.
- Drives word-by-word writes into the cache data array, and writes the tag array when the last word lands.

---
 rtl/cache_fill_fsm_if.sv | 40 ++++
 rtl/cache_fill_fsm.sv | 106 ++++++++++
 tb/tb_cache_fill_fsm.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_fsm_if.sv
// rtl/cache_fill_fsm_if.sv - miss/memory/cache-array signal bundle for cache_fill_fsm
//
// Purpose: groups the miss request, memory read channel and cache array
// write strobes of the block fill engine.
//   master : the fill FSM (samples miss and memory data, drives requests/writes)
//   slave  : the cache miss logic plus memory model side
// Signals:
//   miss_detected, miss_address[15:0]     miss request from the cache
//   memory_data[15:0], memory_data_valid  read return from memory
//   fsm_busy                              fill in progress
//   mem_read_en, memory_address[15:0]     word read request
//   write_data_array, word_index, fill_data  data array write
//   write_tag_array                       tag/valid write for the block
interface cache_fill_fsm_if #(
    parameter int IDX_W = 3
);
    logic              miss_detected;
    logic [15:0]       miss_address;
    logic [15:0]       memory_data;
    logic              memory_data_valid;
    logic              fsm_busy;
    logic              mem_read_en;
    logic [15:0]       memory_address;
    logic              write_data_array;
    logic [IDX_W-1:0]  word_index;
    logic [15:0]       fill_data;
    logic              write_tag_array;

    modport master (
        input  miss_detected, miss_address, memory_data, memory_data_valid,
        output fsm_busy, mem_read_en, memory_address, write_data_array,
               word_index, fill_data, write_tag_array
    );

    modport slave (
        output miss_detected, miss_address, memory_data, memory_data_valid,
        input  fsm_busy, mem_read_en, memory_address, write_data_array,
               word_index, fill_data, write_tag_array
    );
endinterface

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache block fill engine: word requests, counted responses, tag write
//
// Purpose: on a miss seen in IDLE, issues one read per cycle for every word
// of the aligned block, writes each returning word into the data array in
// arrival order and writes the tag array together with the last word.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  cache_fill_fsm_if.master (miss in, memory read channel, array writes)
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8,
    parameter int IDX_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    cache_fill_fsm_if.master bus
);
    localparam logic [IDX_W-1:0] LAST     = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [15:0]      OFF_MASK = 16'(2 * BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [15:0]      base, base_nxt;
    logic [IDX_W-1:0] req_cnt, req_cnt_nxt;
    logic [IDX_W-1:0] rsp_cnt, rsp_cnt_nxt;
    logic             rsp_take;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            base    <= '0;
            req_cnt <= '0;
            rsp_cnt <= '0;
        end else begin
            state   <= state_nxt;
            base    <= base_nxt;
            req_cnt <= req_cnt_nxt;
            rsp_cnt <= rsp_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        base_nxt    = base;
        req_cnt_nxt = req_cnt;
        rsp_cnt_nxt = rsp_cnt;
        rsp_take    = 1'b0;

        bus.fsm_busy         = 1'b0;
        bus.mem_read_en      = 1'b0;
        bus.memory_address   = '0;
        bus.write_data_array = 1'b0;
        bus.word_index       = '0;
        bus.write_tag_array  = 1'b0;
        // Held at zero while reset is asserted so every output reads 0.
        bus.fill_data        = rst ? bus.memory_data : '0;

        case (state)
            IDLE: begin
                // Valid pulses here are stale (post-completion or post-reset).
                if (bus.miss_detected) begin
                    base_nxt    = bus.miss_address & ~OFF_MASK;
                    req_cnt_nxt = '0;
                    rsp_cnt_nxt = '0;
                    state_nxt   = FILL;
                end
            end
            FILL: begin
                bus.fsm_busy       = 1'b1;
                bus.mem_read_en    = 1'b1;
                // base has its offset bits clear, so OR keeps the request
                // inside the block and never carries into the tag bits.
                bus.memory_address = base | {{(15 - IDX_W){1'b0}}, req_cnt, 1'b0};
                req_cnt_nxt        = req_cnt + IDX_W'(1);
                if (req_cnt == LAST) begin
                    state_nxt = DRAIN;
                end
                // Once every request issued so far has been answered, a
                // further valid has no request behind it and is dropped.
                rsp_take = bus.memory_data_valid && (rsp_cnt != req_cnt);
            end
            DRAIN: begin
                bus.fsm_busy = 1'b1;
                rsp_take     = bus.memory_data_valid;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (rsp_take) begin
            bus.write_data_array = 1'b1;
            bus.word_index       = rsp_cnt;
            rsp_cnt_nxt          = rsp_cnt + IDX_W'(1);
            if (rsp_cnt == LAST) begin
                bus.write_tag_array = 1'b1;
                state_nxt           = IDLE;
            end
        end
    end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - randomized self-checking bench for cache_fill_fsm (8- and 4-word blocks)
module tb_cache_fill_fsm;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_fill_fsm_if #(.IDX_W(3)) bus8 ();
    cache_fill_fsm_if #(.IDX_W(2)) bus4 ();

    cache_fill_fsm #(.BLOCK_WORDS(8), .IDX_W(3)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.master)
    );

    cache_fill_fsm #(.BLOCK_WORDS(4), .IDX_W(2)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.master)
    );

    logic        sel = 1'b0;
    logic        m_miss = 1'b0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_data = '0;
    logic        m_valid = 1'b0;

    assign bus8.miss_detected     = !sel && m_miss;
    assign bus8.miss_address      = m_addr;
    assign bus8.memory_data       = m_data;
    assign bus8.memory_data_valid = !sel && m_valid;
    assign bus4.miss_detected     = sel && m_miss;
    assign bus4.miss_address      = m_addr;
    assign bus4.memory_data       = m_data;
    assign bus4.memory_data_valid = sel && m_valid;

    wire        o_busy = sel ? bus4.fsm_busy : bus8.fsm_busy;
    wire        o_rd   = sel ? bus4.mem_read_en : bus8.mem_read_en;
    wire [15:0] o_addr = sel ? bus4.memory_address : bus8.memory_address;
    wire        o_wr   = sel ? bus4.write_data_array : bus8.write_data_array;
    wire [3:0]  o_idx  = sel ? {2'b00, bus4.word_index} : {1'b0, bus8.word_index};
    wire [15:0] o_fd   = sel ? bus4.fill_data : bus8.fill_data;
    wire        o_tag  = sel ? bus4.write_tag_array : bus8.write_tag_array;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, o_busy, 0);
        check({tag, " rd"},   o_rd,   0);
        check({tag, " addr"}, o_addr, 0);
        check({tag, " wr"},   o_wr,   0);
        check({tag, " idx"},  o_idx,  0);
        check({tag, " fd"},   o_fd,   0);
        check({tag, " tag"},  o_tag,  0);
    endtask

    // One block fill seen as a schedule: requests in cycles 1..bw, word i
    // returns lat cycles after its request, words from stall_w onward are
    // pushed back by stall_len. Cycle 0 is the cycle the miss is presented.
    // Spurious valids are injected in cycle 0 and in the IDLE cycle after
    // completion. With hold, miss stays high with address alt throughout,
    // so the IDLE cycle after completion launches the next fill
    // (continued by a call with start_t=1).
    task automatic run_fill(input int bw, input logic [15:0] addr, input int lat,
                            input int stall_w, input int stall_len, input bit hold,
                            input logic [15:0] alt, input int start_t, input bit ramp);
        logic [15:0] base;
        logic [15:0] wd [16];
        int          rc [16];
        int          last;
        int          w;
        base = addr & ~16'(2 * bw - 1);
        for (int i = 0; i < bw; i++) begin
            rc[i] = i + 1 + lat + ((i >= stall_w) ? stall_len : 0);
            wd[i] = ramp ? 16'hA000 + 16'(i) : 16'($urandom);
        end
        last = rc[bw - 1];
        sel  = (bw == 4);
        for (int t = start_t; t <= last + 1; t++) begin
            w = -1;
            for (int i = 0; i < bw; i++) begin
                if (rc[i] == t) w = i;
            end
            m_miss  = (t == 0) || hold;
            m_addr  = (t == 0) ? addr : (hold ? alt : 16'($urandom));
            m_valid = (w >= 0) || (t == 0) || (t == last + 1);
            m_data  = (w >= 0) ? wd[w] : 16'($urandom);
            @(negedge clk);
            check($sformatf("busy %h t%0d", addr, t), o_busy, (t >= 1 && t <= last));
            check($sformatf("rd %h t%0d", addr, t), o_rd, (t >= 1 && t <= bw));
            check($sformatf("addr %h t%0d", addr, t), o_addr,
                  (t >= 1 && t <= bw) ? base + 16'(2 * (t - 1)) : 16'h0000);
            check($sformatf("wr %h t%0d", addr, t), o_wr, (w >= 0));
            check($sformatf("tag %h t%0d", addr, t), o_tag, (t == last));
            if (w >= 0) begin
                check($sformatf("idx %h t%0d", addr, t), o_idx, w);
                check($sformatf("fd %h t%0d", addr, t), o_fd, wd[w]);
            end
            @(posedge clk);
            #1;
        end
        m_miss  = 1'b0;
        m_valid = 1'b0;
    endtask

    initial begin
        int bw;
        m_data  = 16'hBEEF;
        m_valid = 1'b1;
        m_miss  = 1'b1;
        @(negedge clk);
        sel = 1'b0;
        #1;
        check_all_zero("reset8");
        sel = 1'b1;
        #1;
        check_all_zero("reset4");
        m_valid = 1'b0;
        m_miss  = 1'b0;
        sel     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_fill(8, 16'h1234, 4, 8, 0, 1'b0, 16'h0000, 0, 1'b1);
        run_fill(8, 16'hFFFF, 4, 8, 0, 1'b0, 16'h0000, 0, 1'b0);
        run_fill(8, 16'h2000, 4, 8, 0, 1'b1, 16'h4000, 0, 1'b0);
        run_fill(8, 16'h4000, 4, 8, 0, 1'b0, 16'h0000, 1, 1'b0);
        run_fill(8, 16'h5A5B, 1, 3, 2, 1'b0, 16'h0000, 0, 1'b0);
        run_fill(4, 16'h00F9, 4, 4, 0, 1'b0, 16'h0000, 0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            bw = ($urandom_range(0, 1) == 0) ? 8 : 4;
            run_fill(bw, 16'($urandom), $urandom_range(1, 6), $urandom_range(0, bw),
                     $urandom_range(0, 3), 1'b0, 16'h0000, 0, 1'b0);
        end

        // Reset in the middle of a fill, between clock edges.
        sel     = 1'b0;
        m_miss  = 1'b1;
        m_addr  = 16'h3456;
        m_valid = 1'b0;
        @(posedge clk);
        #1;
        m_miss = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            m_valid = (t == 5);
            m_data  = 16'($urandom);
            @(posedge clk);
            #1;
        end
        m_valid = 1'b1;
        m_data  = 16'h7777;
        check("midfill busy before rst", o_busy, 1);
        check("midfill wr before rst", o_wr, 1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async rst");
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int t = 0; t < 6; t++) begin
            m_valid = 1'b1;
            m_data  = 16'($urandom);
            @(negedge clk);
            check($sformatf("late wr %0d", t), o_wr, 0);
            check($sformatf("late tag %0d", t), o_tag, 0);
            check($sformatf("late busy %0d", t), o_busy, 0);
            @(posedge clk);
            #1;
        end
        m_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
